check_cache: RTL and testbench

CHECK_CACHE -- requirements
Module: check_cache

---
 rtl/check_cache.sv | 224 ++++++++++++++++++++++
 tb/tb_check_cache.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/check_cache.sv
// 8-way set-associative tag/state directory with tree pseudo-LRU replacement.
// Optional statistics counters are enabled by defining CHECK_CACHE_STATS_EN.
module check_cache #(
  parameter int INDEX_W = 14,
  parameter int TAG_W   = 12,
  parameter int WAYS    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [1:0]         req_op,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [2:0]         req_way,
  input  logic [1:0]         req_dv,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [2:0]         rsp_way,
  output logic               rsp_victim_dirty,
  output logic [TAG_W-1:0]   rsp_victim_tag,
  output logic [31:0]        stat_lookups,
  output logic [31:0]        stat_hits
);

  localparam int SETS = 1 << INDEX_W;

  localparam logic [1:0] OP_LOOKUP   = 2'b00;
  localparam logic [1:0] OP_ALLOCATE = 2'b01;
  localparam logic [1:0] OP_UPDATE   = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  // State bits live in flops so CLEAR can wipe every set in one cycle.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [6:0]       plru_q  [SETS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];

  logic [WAYS-1:0]  cur_valid, cur_dirty, match;
  logic [6:0]       cur_plru;
  logic [TAG_W-1:0] cur_tags [WAYS];

  logic             hit;
  logic [2:0]       hit_way, inv_way, plru_way, victim;
  logic [2:0]       walk_node;

  logic             set_we, clear_all, tag_we;
  logic [2:0]       tag_way;
  logic [WAYS-1:0]  valid_d, dirty_d;
  logic [6:0]       plru_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [2:0]       rsp_way_q, rsp_way_d;
  logic             rsp_vd_q, rsp_vd_d;
  logic [TAG_W-1:0] rsp_vtag_q, rsp_vtag_d;

  function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] r;
    logic [2:0] n1, n2;
    r     = p;
    n1    = 3'd1 + {2'b00, w[2]};
    n2    = 3'd3 + {1'b0, w[2:1]};
    r[0]  = ~w[2];
    r[n1] = ~w[1];
    r[n2] = ~w[0];
    return r;
  endfunction

  assign cur_valid = valid_q[req_index];
  assign cur_dirty = dirty_q[req_index];
  assign cur_plru  = plru_q[req_index];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign cur_tags[gi] = tag_mem[req_index][gi];
    assign match[gi]    = cur_valid[gi] && (cur_tags[gi] == req_tag);
  end

  assign hit = |match;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i])      hit_way = 3'(i);
      if (!cur_valid[i]) inv_way = 3'(i);
    end
  end

  // Tree walk: root, then the half node, then the pair node.
  assign plru_way[2] = cur_plru[0];
  assign plru_way[1] = cur_plru[0] ? cur_plru[2] : cur_plru[1];
  assign walk_node   = 3'd3 + {1'b0, plru_way[2:1]};
  assign plru_way[0] = cur_plru[walk_node];
  assign victim      = (&cur_valid) ? plru_way : inv_way;

  always_comb begin
    set_we      = 1'b0;
    clear_all   = 1'b0;
    tag_we      = 1'b0;
    tag_way     = victim;
    valid_d     = cur_valid;
    dirty_d     = cur_dirty;
    plru_d      = cur_plru;
    rsp_valid_d = req_valid;
    rsp_hit_d   = 1'b0;
    rsp_way_d   = '0;
    rsp_vd_d    = 1'b0;
    rsp_vtag_d  = '0;
    if (req_valid) begin
      case (req_op)
        OP_LOOKUP: begin
          if (hit) begin
            rsp_hit_d = 1'b1;
            rsp_way_d = hit_way;
            set_we    = 1'b1;
            plru_d    = plru_touch(cur_plru, hit_way);
          end else begin
            rsp_way_d  = victim;
            rsp_vd_d   = cur_dirty[victim];
            rsp_vtag_d = cur_tags[victim];
          end
        end
        OP_ALLOCATE: begin
          rsp_way_d       = victim;
          rsp_vd_d        = cur_dirty[victim];
          rsp_vtag_d      = cur_tags[victim];
          set_we          = 1'b1;
          tag_we          = 1'b1;
          valid_d[victim] = req_dv[1];
          dirty_d[victim] = req_dv[0];
          plru_d          = plru_touch(cur_plru, victim);
        end
        OP_UPDATE: begin
          rsp_hit_d        = cur_valid[req_way];
          rsp_way_d        = req_way;
          set_we           = 1'b1;
          valid_d[req_way] = req_dv[1];
          dirty_d[req_way] = req_dv[0];
          plru_d           = plru_touch(cur_plru, req_way);
        end
        OP_CLEAR: clear_all = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= '0;
        dirty_q[i] <= '0;
        plru_q[i]  <= '0;
      end
    end else if (clear_all) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= '0;
        dirty_q[i] <= '0;
        plru_q[i]  <= '0;
      end
    end else if (set_we) begin
      valid_q[req_index] <= valid_d;
      dirty_q[req_index] <= dirty_d;
      plru_q[req_index]  <= plru_d;
    end
  end

  // Tags are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[req_index][tag_way] <= req_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_vd_q    <= 1'b0;
      rsp_vtag_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_way_q   <= rsp_way_d;
      rsp_vd_q    <= rsp_vd_d;
      rsp_vtag_q  <= rsp_vtag_d;
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_victim_dirty = rsp_vd_q;
  assign rsp_victim_tag   = rsp_vtag_q;

`ifdef CHECK_CACHE_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_hits_d    = stat_hits_q;
    if (req_valid && req_op == OP_LOOKUP) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
      if (hit) stat_hits_d = stat_hits_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
`else
  assign stat_lookups = '0;
  assign stat_hits    = '0;
`endif

endmodule

// File: tb/tb_check_cache.sv
// Scoreboard bench for check_cache: driver queues expected responses, a monitor checks them.
module tb_check_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [13:0] req_index = '0;
  logic [11:0] req_tag = '0;
  logic [2:0]  req_way = '0;
  logic [1:0]  req_dv = '0;
  logic        rsp_valid, rsp_hit, rsp_victim_dirty;
  logic [2:0]  rsp_way;
  logic [11:0] rsp_victim_tag;
  logic [31:0] stat_lookups, stat_hits;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      nm;
    logic       hit;
    logic [2:0] way;
    logic       vd;
    logic [11:0] vtag;
    bit         chk_tag;
  } exp_t;
  exp_t sb[$];

  check_cache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_index(req_index), .req_tag(req_tag), .req_way(req_way), .req_dv(req_dv),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got hit=%0b way=%0d with nothing outstanding", rsp_hit, rsp_way);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_hit !== e.hit || rsp_way !== e.way || rsp_victim_dirty !== e.vd ||
            (e.chk_tag && rsp_victim_tag !== e.vtag)) begin
          bad++;
          $display("FAIL %s: got hit=%0b way=%0d vd=%0b vtag=%h, want hit=%0b way=%0d vd=%0b vtag=%h",
                   e.nm, rsp_hit, rsp_way, rsp_victim_dirty, rsp_victim_tag,
                   e.hit, e.way, e.vd, e.vtag);
        end else begin
          $display("ok %s: hit=%0b way=%0d vd=%0b vtag=%h", e.nm, rsp_hit, rsp_way,
                   rsp_victim_dirty, rsp_victim_tag);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end else begin
      $display("ok %s: %0h", nm, got);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int idx, input int tag, input int way,
                       input logic [1:0] dv, input string nm, input logic eh, input int ew,
                       input logic evd, input int et, input bit ct);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx[13:0];
    req_tag   = tag[11:0];
    req_way   = way[2:0];
    req_dv    = dv;
    e.nm = nm; e.hit = eh; e.way = ew[2:0]; e.vd = evd; e.vtag = et[11:0]; e.chk_tag = ct;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid}, 0);
    check("rst_hit", {31'd0, rsp_hit}, 0);
    check("rst_way", {29'd0, rsp_way}, 0);
    check("rst_vd", {31'd0, rsp_victim_dirty}, 0);
    check("rst_vtag", {20'd0, rsp_victim_tag}, 0);
    check("rst_stats", stat_lookups | stat_hits, 0);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int idx, input int base);
    for (int i = 0; i < 8; i++)
      issue(2'b01, idx, base + i, 0, 2'b10, $sformatf("fill%0d_w%0d", idx, i), 1'b0, i, 1'b0, 0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // basic miss / allocate / hit, plus a second miss picking the next free way
    issue(2'b00, 5, 'hABC, 0, 2'b00, "lk_miss", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b01, 5, 'hABC, 0, 2'b10, "alloc_abc", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'hABC, 0, 2'b00, "lk_hit", 1'b1, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'hDEF, 0, 2'b00, "lk_miss_w1", 1'b0, 1, 1'b0, 0, 1'b0);
    drain();
`ifdef CHECK_CACHE_STATS_EN
    check("stat_lookups", stat_lookups, 3);
    check("stat_hits", stat_hits, 1);
`else
    check("stat_lookups", stat_lookups, 0);
    check("stat_hits", stat_hits, 0);
`endif

    // full set, PLRU victim after in-order fill is way 0
    do_reset();
    fill(5, 1);
    issue(2'b01, 5, 'h009, 0, 2'b10, "plru_victim0", 1'b0, 0, 1'b0, 'h001, 1'b1);
    drain();

    // hit on way 0 steers the tree to way 4
    do_reset();
    fill(5, 1);
    issue(2'b00, 5, 'h001, 0, 2'b00, "touch_w0", 1'b1, 0, 1'b0, 0, 1'b0);
    issue(2'b01, 5, 'h009, 0, 2'b10, "plru_victim4", 1'b0, 4, 1'b0, 'h005, 1'b1);
    drain();

    // dirty victim, then invalidate and re-pick
    do_reset();
    fill(5, 1);
    issue(2'b10, 5, 0, 0, 2'b11, "upd_dirty", 1'b1, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'h002, 0, 2'b00, "touch_w1", 1'b1, 1, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'h003, 0, 2'b00, "touch_w2", 1'b1, 2, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'h008, 0, 2'b00, "touch_w7", 1'b1, 7, 1'b0, 0, 1'b0);
    issue(2'b01, 5, 'h00A, 0, 2'b10, "dirty_victim", 1'b0, 0, 1'b1, 'h001, 1'b1);
    issue(2'b10, 5, 0, 0, 2'b00, "upd_inval", 1'b1, 0, 1'b0, 0, 1'b0);
    issue(2'b01, 5, 'h00B, 0, 2'b10, "refill_w0", 1'b0, 0, 1'b0, 'h00A, 1'b1);
    issue(2'b10, 5, 0, 3, 2'b10, "upd_valid_w3", 1'b1, 3, 1'b0, 0, 1'b0);
    drain();

    // CLEAR wipes everything in one cycle
    fill(3, 'h10);
    issue(2'b11, 0, 0, 0, 2'b00, "clear", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 3, 'h10, 0, 2'b00, "lk_after_clr", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'h00B, 0, 2'b00, "lk5_after_clr", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b10, 3, 0, 6, 2'b10, "upd_after_clr", 1'b0, 6, 1'b0, 0, 1'b0);
    drain();

    // reset between request and response aborts it
    issue(2'b01, 5, 'h044, 0, 2'b11, "alloc_44", 1'b0, 0, 1'b0, 0, 1'b0);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_index = 14'd5; req_tag = 12'h055; req_dv = 2'b11;
    #2 rst_n = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_no_rsp", {31'd0, rsp_valid}, 0);
    #1 rst_n = 1'b1;
    issue(2'b00, 5, 'h044, 0, 2'b00, "lk_after_abort", 1'b0, 0, 1'b0, 0, 1'b0);
    issue(2'b00, 5, 'h055, 0, 2'b00, "lk55_after_abort", 1'b0, 0, 1'b0, 0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
